// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch front end.
//   NOP_INSTR        : bubble presented to decode when no fetched word is available
//   DEFAULT_RESET_PC : fetch PC after reset unless overridden at the top level
//   fetch_entry_t    : one buffered fetch, instruction word plus its PC
package fetch_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Generic synchronous FIFO with flush and asynchronous active-high reset.
//   i_clk, i_reset : clock and async reset (clears pointers and count)
//   i_push, i_wdata: write i_wdata at the tail (ignored when full)
//   i_pop          : drop the head entry (ignored when empty)
//   i_flush        : empty the FIFO; overrides push and pop
//   o_rdata        : head entry (meaningful only when not empty)
//   o_full, o_empty, o_count : occupancy
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign o_full  = (r_count == FULL_COUNT);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  assign w_push = i_push & ~o_full  & ~i_flush;
  assign w_pop  = i_pop  & ~o_empty & ~i_flush;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; the head is only consumed when not empty.
  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Decoupled instruction fetch front end. Owns the fetch PC, reads words on
// the shared memory port whenever it is granted, buffers {instr, pc} pairs and
// presents the head entry to decode (NOP bubble when empty).
//   clk, reset            : clock, async active-high reset
//   mem_grant             : memory port free for fetch this cycle
//   mem_req, mem_adr      : fetch request and word-aligned address
//   mem_rdata             : combinational read data for mem_adr
//   redirect, redirect_pc : taken branch/jump and its target
//   stall                 : decode holds the current output
//   instr, instr_pc, instr_pc_plus_4, instr_valid : head entry to decode
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_grant,
  output logic        mem_req,
  output logic [31:0] mem_adr,
  input  logic [31:0] mem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pc_plus_4,
  output logic        instr_valid
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0]  r_fetch_pc;
  fetch_entry_t w_push_entry;
  fetch_entry_t w_head;
  logic         w_full;
  logic         w_empty;
  logic [AW:0]  w_count;
  logic         w_push;
  logic         w_pop;

  // Request depends on registered occupancy only; redirect is the one
  // combinational control input feeding mem_req.
  assign mem_req = ~w_full & ~redirect;
  assign mem_adr = {r_fetch_pc[31:2], 2'b00};
  assign w_push  = mem_req & mem_grant;

  assign instr_valid = (w_count != '0);
  assign w_pop       = instr_valid & ~stall & ~redirect;

  assign w_push_entry.instr = mem_rdata;
  assign w_push_entry.pc    = mem_adr;

  fetch_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (DEPTH)
  ) instr_fifo (
    .i_clk   (clk),
    .i_reset (reset),
    .i_push  (w_push),
    .i_wdata (w_push_entry),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc & ~32'h3;
    end else if (w_push) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
    end
  end

  assign instr           = w_empty ? NOP_INSTR : w_head.instr;
  assign instr_pc        = w_empty ? 32'h0     : w_head.pc;
  assign instr_pc_plus_4 = w_empty ? 32'h0     : w_head.pc + 32'd4;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus random grant/stall/
// redirect traffic, compared every cycle against a queue-based model.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_grant;
  logic        mem_req;
  logic [31:0] mem_adr;
  logic [31:0] mem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pc_plus_4;
  logic        instr_valid;

  logic [31:0] mem_key;
  assign mem_rdata = mem_adr ^ mem_key;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .DEPTH    (DEPTH),
    .RESET_PC (RESET_PC)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .mem_grant       (mem_grant),
    .mem_req         (mem_req),
    .mem_adr         (mem_adr),
    .mem_rdata       (mem_rdata),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .stall           (stall),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_pc_plus_4 (instr_pc_plus_4),
    .instr_valid     (instr_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: buffered fetches in order, plus the next fetch address.
  logic [31:0] q_instr[$];
  logic [31:0] q_pc[$];
  logic [31:0] m_pc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, ".valid"}, {31'b0, instr_valid}, 32'd0);
    check({tag, ".instr"}, instr, NOP);
    check({tag, ".pc"}, instr_pc, 32'd0);
    check({tag, ".pc4"}, instr_pc_plus_4, 32'd0);
    check({tag, ".req"}, {31'b0, mem_req}, 32'd1);
    check({tag, ".adr"}, mem_adr, RESET_PC);
  endtask

  task automatic model_reset();
    q_instr.delete();
    q_pc.delete();
    m_pc = RESET_PC;
  endtask

  // Reset is released with grant low and the FIFO empty, so the edge between
  // release and the next step changes nothing.
  task automatic apply_reset(input logic [31:0] key);
    reset       = 1'b1;
    mem_grant   = 1'b0;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    mem_key     = key;
    #1;
    check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic step(input logic g, input logic s, input logic r, input logic [31:0] rpc);
    logic        exp_req;
    logic        do_push;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_pc;
    logic [31:0] exp_p4;
    @(negedge clk);
    mem_grant   = g;
    stall       = s;
    redirect    = r;
    redirect_pc = rpc;
    #1;
    exp_req   = (q_pc.size() != DEPTH) && !r;
    exp_valid = (q_pc.size() != 0);
    if (exp_valid) begin
      exp_instr = q_instr[0];
      exp_pc    = q_pc[0];
      exp_p4    = q_pc[0] + 32'd4;
    end else begin
      exp_instr = NOP;
      exp_pc    = 32'h0;
      exp_p4    = 32'h0;
    end
    check("mem_req", {31'b0, mem_req}, {31'b0, exp_req});
    check("mem_adr", mem_adr, m_pc);
    check("instr_valid", {31'b0, instr_valid}, {31'b0, exp_valid});
    check("instr", instr, exp_instr);
    check("instr_pc", instr_pc, exp_pc);
    check("instr_pc_plus_4", instr_pc_plus_4, exp_p4);
    if (r) begin
      q_instr.delete();
      q_pc.delete();
      m_pc = rpc & ~32'h3;
    end else begin
      do_push = exp_req && g;
      if (exp_valid && !s) begin
        void'(q_instr.pop_front());
        void'(q_pc.pop_front());
      end
      if (do_push) begin
        q_instr.push_back(m_pc ^ mem_key);
        q_pc.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  initial begin
    logic        g, s, r;
    logic [31:0] rpc;

    apply_reset(32'h0);

    // Streaming with continuous grant: one instruction per cycle.
    repeat (6) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Decode stall longer than the FIFO depth, then release.
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (7) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Data stage owns the port for a while: drain, bubble, resume.
    repeat (2) step(1'b1, 1'b1, 1'b0, 32'h0);
    repeat (4) step(1'b0, 1'b0, 1'b0, 32'h0);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Redirect to a misaligned target while entries are buffered and stalled.
    repeat (4) step(1'b1, 1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 1'b1, 32'h0000_0103);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Fetch PC wrap at the top of the address space.
    step(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
    repeat (3) step(1'b1, 1'b0, 1'b0, 32'h0);

    // Async reset with a full FIFO, between clock edges.
    repeat (6) step(1'b1, 1'b1, 1'b0, 32'h0);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("async_reset");
    apply_reset($urandom);

    // Random traffic with a non-trivial memory pattern.
    for (int i = 0; i < 600; i++) begin
      g = ($urandom_range(0, 9) < 7);
      s = ($urandom_range(0, 9) < 3);
      r = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 3) == 0) rpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 15));
      else                           rpc = $urandom;
      step(g, s, r, rpc);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
